// File: rtl/compadder.sv
// Registered compound adder: one shared propagate/generate datapath feeding two
// parallel ripple carry chains (carry-in 0 and 1) to produce a+b and a+b+1.
module compadder #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   tum
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   s0;
    logic [WIDTH:0]   s1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            logic cin0;
            logic cin1;
            logic cout0;
            logic cout1;

            // Carries are kept local to each cell so the chains stay acyclic per net.
            if (i == 0) begin : g_lsb
                assign cin0 = 1'b0;
                assign cin1 = 1'b1;
            end else begin : g_chain
                assign cin0 = g_fa[i-1].cout0;
                assign cin1 = g_fa[i-1].cout1;
            end

            assign p[i]  = a[i] ^ b[i];
            assign g[i]  = a[i] & b[i];
            assign cout0 = g[i] | (p[i] & cin0);
            assign cout1 = g[i] | (p[i] & cin1);
            assign s0[i] = p[i] ^ cin0;
            assign s1[i] = p[i] ^ cin1;
        end
    endgenerate

    assign s0[WIDTH] = g_fa[WIDTH-1].cout0;
    assign s1[WIDTH] = g_fa[WIDTH-1].cout1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            tum <= '0;
        end else begin
            sum <= s0;
            tum <= s1;
        end
    end

endmodule

// File: tb/tb_compadder.sv
// Scoreboard bench for compadder (WIDTH=3): directed corners, exhaustive sweep,
// random pairs, and asynchronous reset behaviour.
module tb_compadder;

    localparam int W = 3;

    typedef struct packed {
        logic [W:0] s;
        logic [W:0] t;
        logic       ex;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    logic [W:0]   tum;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   ex_checked;

    compadder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .tum   (tum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: plain unsigned arithmetic on integers, truncated to the output width.
    task automatic issue(input int unsigned av, input int unsigned bv, input logic ex);
        exp_t e;
        int unsigned s;
        @(negedge clk);
        a = av[W-1:0];
        b = bv[W-1:0];
        s = av + bv;
        e.s  = s[W:0];
        e.t  = s[W:0] + 1'b1;
        e.ex = ex;
        if (s + 1 > (1 << (W + 1)) - 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL model_range: got %0d, expected <= %0d", s + 1, (1 << (W + 1)) - 1);
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every active edge out of reset presents one result for the oldest issued pair.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && exp_q.size() != 0) begin
                #1;
                e = exp_q.pop_front();
                check("sum", sum, e.s);
                check("tum", tum, e.t);
                if (e.ex) ex_checked++;
            end
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        ex_checked = 0;
        rst_n      = 1'b0;
        a          = 3'd7;
        b          = 3'd7;

        #2;
        check("reset_sum_async", sum, 4'd0);
        check("reset_tum_async", tum, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sum_held", sum, 4'd0);
        check("reset_tum_held", tum, 4'd0);

        rst_n = 1'b1;
        issue(7, 7, 1'b0);
        issue(0, 0, 1'b0);
        issue(7, 7, 1'b0);
        issue(5, 3, 1'b0);
        issue(7, 0, 1'b0);

        for (int ia = 0; ia < (1 << W); ia++)
            for (int ib = 0; ib < (1 << W); ib++)
                issue(ia, ib, 1'b1);

        for (int k = 0; k < 200; k++)
            issue($urandom_range((1 << W) - 1), $urandom_range((1 << W) - 1), 1'b0);

        drain();
        check("exhaustive_count", 7'(ex_checked), 7'd64);

        issue(6, 5, 1'b0);
        drain();
        rst_n = 1'b0;
        #1;
        check("midreset_sum", sum, 4'd0);
        check("midreset_tum", tum, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postreset_sum_pre_edge", sum, 4'd0);
        check("postreset_tum_pre_edge", tum, 4'd0);
        begin
            exp_t e;
            e.s  = 4'd11;
            e.t  = 4'd12;
            e.ex = 1'b0;
            exp_q.push_back(e);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
